// File: rtl/lfsr_seq_ctrl.sv
// Run sequencer around a seedable 20-bit XNOR LFSR: emits a programmed number
// of words over valid/ready, with seed load, start, abort, done and lock-up guard.
module lfsr_seq_ctrl #(
  parameter int                 WIDTH    = 20,
  parameter int                 CNT_W    = 16,
  parameter logic [WIDTH-1:0]   DEF_SEED = 20'h00101
) (
  input  logic               clk,
  input  logic               nreset,
  input  logic               seed_we,
  input  logic [WIDTH-1:0]   seed_in,
  input  logic [CNT_W-1:0]   num_words,
  input  logic               start,
  input  logic               abort,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               seed_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CMPL = 2'd2;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] v);
    return {v[WIDTH-2:0], ~(v[6] ^ v[WIDTH-1])};
  endfunction

  // All-ones is the XNOR lock-up state: the register would never leave it.
  function automatic logic is_lockup(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [WIDTH-1:0] seed_r;
  logic [WIDTH-1:0] lfsr_r;
  logic [CNT_W-1:0] rem_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;
  logic             seed_err_r;

  logic             hs_s;
  logic             idle_like_s;
  logic             start_ok_s;
  logic             load_run_s;
  logic             last_s;
  logic             done_set_s;
  logic             seed_load_s;
  logic             err_set_s;
  logic [WIDTH-1:0] seed_sub_s;
  logic [WIDTH-1:0] eff_seed_s;

  // State register.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; abort wins over start and over the final handshake.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_CMPL: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (start) begin
          state_nxt_s = (num_words != '0) ? ST_RUN : ST_CMPL;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt_s = ST_IDLE;
        end else if (last_s) begin
          state_nxt_s = ST_CMPL;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Output/datapath control decode.
  always_comb begin
    hs_s        = valid_r & out_ready;
    idle_like_s = (state_r == ST_IDLE) || (state_r == ST_CMPL);
    start_ok_s  = idle_like_s & start & ~abort;
    load_run_s  = start_ok_s & (num_words != '0);
    last_s      = (state_r == ST_RUN) & hs_s & (rem_r == CNT_W'(1));
    done_set_s  = ~abort & ((start_ok_s & (num_words == '0)) | last_s);
    seed_load_s = seed_we & idle_like_s;
    err_set_s   = seed_load_s & is_lockup(seed_in);
    if (is_lockup(seed_in)) begin
      seed_sub_s = DEF_SEED;
    end else begin
      seed_sub_s = seed_in;
    end
    if (seed_we) begin
      eff_seed_s = seed_sub_s;
    end else begin
      eff_seed_s = seed_r;
    end
  end

  // Datapath and registered status outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      seed_r     <= DEF_SEED;
      lfsr_r     <= DEF_SEED;
      rem_r      <= '0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      seed_err_r <= 1'b0;
    end else begin
      if (seed_load_s) begin
        seed_r <= seed_sub_s;
      end
      // A handshake in the abort cycle still moves the word out.
      if (load_run_s) begin
        lfsr_r <= eff_seed_s;
      end else if (hs_s) begin
        lfsr_r <= lfsr_step(lfsr_r);
      end
      if (abort) begin
        rem_r <= '0;
      end else if (load_run_s) begin
        rem_r <= num_words;
      end else if (hs_s) begin
        rem_r <= rem_r - CNT_W'(1);
      end
      valid_r    <= (state_nxt_s == ST_RUN);
      busy_r     <= (state_nxt_s == ST_RUN);
      done_r     <= done_set_s;
      seed_err_r <= err_set_s;
    end
  end

  assign out_data  = lfsr_r;
  assign out_valid = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign seed_err  = seed_err_r;

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Directed bench for lfsr_seq_ctrl: cycle model of the run rules checked every
// falling edge, plus literal expectations for the published word sequences.
module tb_lfsr_seq_ctrl;

  localparam logic [19:0] DEF = 20'h00101;

  logic        clk = 1'b0;
  logic        nreset;
  logic        seed_we = 1'b0;
  logic [19:0] seed_in = 20'h00000;
  logic [15:0] num_words = 16'd0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b0;
  logic [19:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic        seed_err;

  int pass_cnt = 0;
  int total_cnt = 0;
  int done_cnt = 0;
  int dc_snap;
  logic [19:0] got[$];

  // Model state, named after the observable behaviour.
  int          m_mode = 0;  // 0 idle, 1 running, 2 complete
  logic [19:0] m_seed = DEF;
  logic [19:0] m_word = DEF;
  int          m_left = 0;
  logic        m_valid = 1'b0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;
  logic        m_hs;
  logic [19:0] m_eff;

  lfsr_seq_ctrl dut (
    .clk(clk), .nreset(nreset), .seed_we(seed_we), .seed_in(seed_in),
    .num_words(num_words), .start(start), .abort(abort),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .seed_err(seed_err)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] next_word(input logic [19:0] x);
    logic [19:0] y;
    y = (x << 1) & 20'hFFFFF;
    y = y | {19'd0, (x[6] == x[19])};
    return y;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_got(input string name, input int n,
                         input logic [19:0] e0, input logic [19:0] e1, input logic [19:0] e2);
    logic [19:0] e[3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    chk({name, "_count"}, got.size(), n);
    for (int i = 0; i < n; i++)
      if (i < got.size()) chk({name, "_word"}, got[i], e[i]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Behavioural model of the run rules.
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_mode = 0; m_seed = DEF; m_word = DEF; m_left = 0;
      m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_hs = m_valid && out_ready;
      m_done = 1'b0;
      m_err = 1'b0;
      m_eff = m_seed;
      if (seed_we) m_eff = (seed_in == 20'hFFFFF) ? DEF : seed_in;
      if (seed_we && m_mode != 1) begin
        m_err = (seed_in == 20'hFFFFF);
        m_seed = m_eff;
      end
      if (abort) begin
        if (m_hs) m_word = next_word(m_word);
        m_mode = 0;
        m_left = 0;
      end else if (m_mode == 1) begin
        if (m_hs) begin
          m_word = next_word(m_word);
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_mode = 2;
            m_done = 1'b1;
          end
        end
      end else if (start) begin
        if (num_words != 16'd0) begin
          m_word = m_eff;
          m_left = int'(num_words);
          m_mode = 1;
        end else begin
          m_mode = 2;
          m_done = 1'b1;
        end
      end
      m_valid = (m_mode == 1);
    end
  end

  // Compare every cycle and record transferred words.
  always @(negedge clk) begin
    chk("out_data", out_data, m_word);
    chk("out_valid", out_valid, m_valid);
    chk("busy", busy, (m_mode == 1));
    chk("done", done, m_done);
    chk("seed_err", seed_err, m_err);
    if (out_valid && out_ready) got.push_back(out_data);
    if (done) done_cnt++;
  end

  initial begin
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", out_data, 20'h00101);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_err", seed_err, 1'b0);
    nreset = 1'b1;
    cyc(1);

    // 1: three words back to back
    got.delete();
    start = 1'b1; num_words = 16'd3; out_ready = 1'b1;
    cyc(1); start = 1'b0;
    chk("t1_first", out_data, 20'h00101);
    chk("t1_valid", out_valid, 1'b1);
    cyc(3);
    chk("t1_done", done, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk_got("t1", 3, 20'h00101, 20'h00203, 20'h00407);
    cyc(1);
    chk("t1_done_end", done, 1'b0);

    // 2: back-pressure on the second word
    got.delete();
    start = 1'b1; num_words = 16'd3;
    cyc(1); start = 1'b0;
    cyc(1);
    out_ready = 1'b0;
    cyc(2);
    chk("t2_hold_data", out_data, 20'h00203);
    chk("t2_hold_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    cyc(1);
    chk("t2_no_early_done", done, 1'b0);
    cyc(1);
    chk("t2_done", done, 1'b1);
    chk_got("t2", 3, 20'h00101, 20'h00203, 20'h00407);

    // 3: lock-up seed rejected
    abort = 1'b1; cyc(1); abort = 1'b0;
    seed_we = 1'b1; seed_in = 20'hFFFFF;
    cyc(1); seed_we = 1'b0;
    chk("t3_err", seed_err, 1'b1);
    cyc(1);
    chk("t3_err_end", seed_err, 1'b0);
    got.delete();
    start = 1'b1; num_words = 16'd1;
    cyc(1); start = 1'b0;
    chk("t3_word", out_data, 20'h00101);
    cyc(1);
    chk("t3_done", done, 1'b1);
    chk_got("t3", 1, 20'h00101, 20'h00000, 20'h00000);

    // 4: zero-length run then a two-word run
    start = 1'b1; num_words = 16'd0;
    cyc(1); start = 1'b0;
    chk("t4_valid", out_valid, 1'b0);
    chk("t4_done", done, 1'b1);
    cyc(1);
    chk("t4_done_end", done, 1'b0);
    got.delete();
    start = 1'b1; num_words = 16'd2;
    cyc(1); start = 1'b0;
    cyc(2);
    chk("t4_done2", done, 1'b1);
    chk_got("t4", 2, 20'h00101, 20'h00203, 20'h00000);

    // 5: abort mid-run
    seed_we = 1'b1; seed_in = 20'h12345;
    cyc(1); seed_we = 1'b0;
    start = 1'b1; num_words = 16'd10;
    cyc(1); start = 1'b0;
    chk("t5_seed", out_data, 20'h12345);
    cyc(1);
    chk("t5_step", out_data, 20'h2468A);
    cyc(3);
    dc_snap = done_cnt;
    abort = 1'b1; cyc(1); abort = 1'b0;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_busy", busy, 1'b0);
    cyc(5);
    chk("t5_no_done", done_cnt, dc_snap);
    start = 1'b1; num_words = 16'd2;
    cyc(1); start = 1'b0;
    chk("t5_restart", out_data, 20'h12345);
    cyc(2);

    // 6: start/seed_we ignored while running, then async reset
    start = 1'b1; num_words = 16'd2;
    cyc(1);
    seed_we = 1'b1; seed_in = 20'h55555; num_words = 16'd7;
    cyc(1); seed_we = 1'b0; start = 1'b0;
    chk("t6_busy", busy, 1'b1);
    chk("t6_data", out_data, 20'h2468A);
    cyc(1);
    chk("t6_done", done, 1'b1);
    start = 1'b1; num_words = 16'd1;
    cyc(1); start = 1'b0;
    chk("t6_seed_kept", out_data, 20'h12345);
    cyc(1);
    start = 1'b1; num_words = 16'd5;
    cyc(1); start = 1'b0;
    cyc(1);
    dc_snap = done_cnt;
    #3 nreset = 1'b0;
    #1;
    chk("t6_rst_data", out_data, 20'h00101);
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_done", done, 1'b0);
    chk("t6_rst_err", seed_err, 1'b0);
    cyc(1);
    nreset = 1'b1;
    cyc(3);
    chk("t6_no_done", done_cnt, dc_snap);
    start = 1'b1; num_words = 16'd1;
    cyc(1); start = 1'b0;
    chk("t6_post_rst", out_data, 20'h00101);
    cyc(2);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
